// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave register file.
// Holds 2**(ADDR_WIDTH-2) registers of DATA_WIDTH bits. Writes honour per-byte
// strobes. Read and write channels are independent. Every access completes OKAY.
// Ports:
//   ACLK, ARESETn                 clock, asynchronous active-low reset
//   AWADDR/AWVALID/AWREADY        write address channel
//   WDATA/WSTRB/WVALID/WREADY     write data channel
//   BVALID/BREADY                 write response channel (no BRESP)
//   ARADDR/ARVALID/ARREADY        read address channel
//   RDATA/RVALID/RREADY           read data channel (no RRESP)
module axi_lite_slave_regs #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic [ADDR_WIDTH-1:0]     AWADDR,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [DATA_WIDTH-1:0]     WDATA,
  input  logic [DATA_WIDTH/8-1:0]   WSTRB,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic                      BVALID,
  input  logic                      BREADY,
  input  logic [ADDR_WIDTH-1:0]     ARADDR,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [DATA_WIDTH-1:0]     RDATA,
  output logic                      RVALID,
  input  logic                      RREADY
);

  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned IDX_W    = ADDR_WIDTH - 2;
  localparam int unsigned NUM_REGS = 2 ** IDX_W;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_HAVE_A = 2'd1,
    W_HAVE_D = 2'd2,
    W_RESP   = 2'd3
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

  wstate_t                r_wstate;
  rstate_t                r_rstate;
  logic [IDX_W-1:0]       r_awidx;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic [STRB_W-1:0]      r_wstrb;
  logic [DATA_WIDTH-1:0]  r_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0]  r_rdata;

  logic                   w_aw_hs;
  logic                   w_w_hs;
  logic                   w_commit;
  logic [IDX_W-1:0]       w_cidx;
  logic [DATA_WIDTH-1:0]  w_cdata;
  logic [STRB_W-1:0]      w_cstrb;
  logic                   w_unused_addr_lsbs;

  // Byte offset within a word carries no meaning for a word register file.
  assign w_unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

  // Handshake outputs decode state only, so no input reaches an output.
  assign AWREADY = (r_wstate == W_IDLE) || (r_wstate == W_HAVE_D);
  assign WREADY  = (r_wstate == W_IDLE) || (r_wstate == W_HAVE_A);
  assign BVALID  = (r_wstate == W_RESP);
  assign ARREADY = (r_rstate == R_IDLE);
  assign RVALID  = (r_rstate == R_DATA);
  assign RDATA   = r_rdata;

  assign w_aw_hs = AWVALID && AWREADY;
  assign w_w_hs  = WVALID && WREADY;

  // Select the commit source: live bus fields for whichever half arrives now,
  // latched fields for the half captured earlier.
  always_comb begin
    w_commit = 1'b0;
    w_cidx   = r_awidx;
    w_cdata  = r_wdata;
    w_cstrb  = r_wstrb;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_commit = 1'b1;
          w_cidx   = AWADDR[ADDR_WIDTH-1:2];
          w_cdata  = WDATA;
          w_cstrb  = WSTRB;
        end
      end
      W_HAVE_A: begin
        if (w_w_hs) begin
          w_commit = 1'b1;
          w_cdata  = WDATA;
          w_cstrb  = WSTRB;
        end
      end
      W_HAVE_D: begin
        if (w_aw_hs) begin
          w_commit = 1'b1;
          w_cidx   = AWADDR[ADDR_WIDTH-1:2];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wstate <= W_IDLE;
      r_awidx  <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_commit) begin
            r_wstate <= W_RESP;
          end else if (w_aw_hs) begin
            r_awidx  <= AWADDR[ADDR_WIDTH-1:2];
            r_wstate <= W_HAVE_A;
          end else if (w_w_hs) begin
            r_wdata  <= WDATA;
            r_wstrb  <= WSTRB;
            r_wstate <= W_HAVE_D;
          end
        end
        W_HAVE_A: if (w_commit) r_wstate <= W_RESP;
        W_HAVE_D: if (w_commit) r_wstate <= W_RESP;
        W_RESP:   if (BREADY)   r_wstate <= W_IDLE;
        default:  r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (w_cstrb[i]) begin
          r_regs[w_cidx][8*i +: 8] <= w_cdata[8*i +: 8];
        end
      end
    end
  end

  // RDATA samples the array before this edge's commit lands, so a same-edge
  // read of the written register returns the old contents.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rstate <= R_IDLE;
      r_rdata  <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (ARVALID) begin
            r_rdata  <= r_regs[ARADDR[ADDR_WIDTH-1:2]];
            r_rstate <= R_DATA;
          end
        end
        R_DATA:  if (RREADY) r_rstate <= R_IDLE;
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
module tb_axi_lite_slave_regs;

  logic        ACLK;
  logic        ARESETn;
  logic [3:0]  AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic        BVALID;
  logic        BREADY;
  logic [3:0]  ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic        RVALID;
  logic        RREADY;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] model [4];

  axi_lite_slave_regs #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    logic [1:0]  awd;
    logic [1:0]  wd;
    logic [1:0]  dly;
  } vec_t;

  vec_t tv [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_commit(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) model[a[3:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int unsigned awd, input int unsigned wd, input int unsigned brd);
    bit aw_done;
    bit w_done;
    int unsigned c;
    aw_done = 1'b0;
    w_done  = 1'b0;
    c = 0;
    AWADDR = a;
    WDATA  = d;
    WSTRB  = s;
    while (!(aw_done && w_done)) begin
      AWVALID = !aw_done && (c >= awd);
      WVALID  = !w_done && (c >= wd);
      @(negedge ACLK);
      if (AWVALID && AWREADY) aw_done = 1'b1;
      if (WVALID && WREADY)   w_done  = 1'b1;
      @(posedge ACLK);
      if (aw_done && w_done) model_commit(a, d, s);
      #1;
      c++;
      if (c > 50) begin
        chk("write_timeout", 32'd1, 32'd0);
        break;
      end
    end
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    chk("bvalid_set", {31'd0, BVALID}, 32'd1);
    for (int unsigned i = 0; i < brd; i++) begin
      @(posedge ACLK); #1;
      chk("bvalid_hold", {31'd0, BVALID}, 32'd1);
    end
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    chk("bvalid_clear", {31'd0, BVALID}, 32'd0);
  endtask

  task automatic do_read(input logic [3:0] a, input int unsigned ard, input int unsigned rrd,
                         input bit use_model, input logic [31:0] exp_in);
    bit done;
    int unsigned c;
    logic [31:0] exp;
    done = 1'b0;
    c = 0;
    exp = exp_in;
    ARADDR = a;
    while (!done) begin
      ARVALID = (c >= ard);
      @(negedge ACLK);
      if (ARVALID && ARREADY) begin
        done = 1'b1;
        if (use_model) exp = model[a[3:2]];
      end
      @(posedge ACLK); #1;
      c++;
      if (c > 50) begin
        chk("read_timeout", 32'd1, 32'd0);
        break;
      end
    end
    ARVALID = 1'b0;
    chk("rvalid_latency", {31'd0, RVALID}, 32'd1);
    chk("rdata", RDATA, exp);
    for (int unsigned i = 0; i < rrd; i++) begin
      @(posedge ACLK); #1;
      chk("rvalid_hold", {31'd0, RVALID}, 32'd1);
      chk("rdata_hold", RDATA, exp);
    end
    RREADY = 1'b1;
    @(posedge ACLK); #1;
    RREADY = 1'b0;
    chk("rvalid_clear", {31'd0, RVALID}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        wr  addr   data           strb   exp            awd wd dly
    tv[0]  = '{1'b0, 4'h0, 32'h0,          4'h0, 32'h00000000, 2'd0, 2'd0, 2'd0};
    tv[1]  = '{1'b0, 4'h4, 32'h0,          4'h0, 32'h00000000, 2'd0, 2'd0, 2'd0};
    tv[2]  = '{1'b0, 4'h8, 32'h0,          4'h0, 32'h00000000, 2'd0, 2'd0, 2'd1};
    tv[3]  = '{1'b0, 4'hC, 32'h0,          4'h0, 32'h00000000, 2'd0, 2'd0, 2'd0};
    tv[4]  = '{1'b1, 4'h4, 32'h01020304,   4'hF, 32'h0,        2'd0, 2'd0, 2'd0};
    tv[5]  = '{1'b0, 4'h4, 32'h0,          4'h0, 32'h01020304, 2'd0, 2'd0, 2'd0};
    tv[6]  = '{1'b1, 4'h8, 32'hAABBCCDD,   4'hF, 32'h0,        2'd1, 2'd0, 2'd1};
    tv[7]  = '{1'b1, 4'h0, 32'h12345678,   4'h3, 32'h0,        2'd0, 2'd2, 2'd0};
    tv[8]  = '{1'b0, 4'h0, 32'h0,          4'h0, 32'h00005678, 2'd0, 2'd0, 2'd2};
    tv[9]  = '{1'b1, 4'h0, 32'hFFFFFFFF,   4'h0, 32'h0,        2'd0, 2'd0, 2'd0};
    tv[10] = '{1'b0, 4'h0, 32'h0,          4'h0, 32'h00005678, 2'd0, 2'd0, 2'd0};
    tv[11] = '{1'b1, 4'h2, 32'hCAFEF00D,   4'hC, 32'h0,        2'd2, 2'd1, 2'd0};
    tv[12] = '{1'b0, 4'h3, 32'h0,          4'h0, 32'hCAFE5678, 2'd0, 2'd0, 2'd0};
    tv[13] = '{1'b0, 4'h8, 32'h0,          4'h0, 32'hAABBCCDD, 2'd0, 2'd0, 2'd0};
    tv[14] = '{1'b0, 4'hC, 32'h0,          4'h0, 32'h00000000, 2'd0, 2'd0, 2'd0};

    for (int i = 0; i < 4; i++) model[i] = '0;
    ARESETn = 1'b0;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    BREADY = 1'b0; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;

    // Reset state
    #23;
    chk("rst_awready", {31'd0, AWREADY}, 32'd1);
    chk("rst_wready",  {31'd0, WREADY},  32'd1);
    chk("rst_arready", {31'd0, ARREADY}, 32'd1);
    chk("rst_bvalid",  {31'd0, BVALID},  32'd0);
    chk("rst_rvalid",  {31'd0, RVALID},  32'd0);
    chk("rst_rdata",   RDATA,            32'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(posedge ACLK); #1;

    // Directed table
    for (int i = 0; i < 15; i++) begin
      if (tv[i].wr)
        do_write(tv[i].addr, tv[i].data, tv[i].strb, tv[i].awd, tv[i].wd, tv[i].dly);
      else
        do_read(tv[i].addr, 0, tv[i].dly, 1'b0, tv[i].exp);
    end

    // Same-cycle AW/W with B backpressure
    AWADDR = 4'h4; WDATA = 32'hDEADBEEF; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1;
    @(posedge ACLK);
    model_commit(4'h4, 32'hDEADBEEF, 4'hF);
    #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    repeat (3) begin
      chk("bp_bvalid",  {31'd0, BVALID},  32'd1);
      chk("bp_awready", {31'd0, AWREADY}, 32'd0);
      chk("bp_wready",  {31'd0, WREADY},  32'd0);
      @(posedge ACLK); #1;
    end
    chk("bp_bvalid_end", {31'd0, BVALID}, 32'd1);
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    chk("bp_bvalid_clear", {31'd0, BVALID}, 32'd0);
    chk("bp_awready_back", {31'd0, AWREADY}, 32'd1);
    do_read(4'h4, 0, 0, 1'b0, 32'hDEADBEEF);

    // W first, AW two cycles later, partial strobe over AABBCCDD
    AWADDR = 4'h8; WDATA = 32'h11223344; WSTRB = 4'h5;
    WVALID = 1'b1;
    @(posedge ACLK); #1;
    WVALID = 1'b0;
    repeat (2) begin
      chk("wfirst_wready",  {31'd0, WREADY},  32'd0);
      chk("wfirst_awready", {31'd0, AWREADY}, 32'd1);
      chk("wfirst_bvalid",  {31'd0, BVALID},  32'd0);
      @(posedge ACLK); #1;
    end
    AWVALID = 1'b1;
    @(posedge ACLK);
    model_commit(4'h8, 32'h11223344, 4'h5);
    #1;
    AWVALID = 1'b0;
    chk("wfirst_bvalid_set", {31'd0, BVALID}, 32'd1);
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    do_read(4'h8, 0, 0, 1'b0, 32'hAA22CC44);

    // Read/write collision on 0xC
    AWADDR = 4'hC; WDATA = 32'h12345678; WSTRB = 4'hF; ARADDR = 4'hC;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    @(posedge ACLK);
    model_commit(4'hC, 32'h12345678, 4'hF);
    #1;
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    chk("coll_rvalid", {31'd0, RVALID}, 32'd1);
    chk("coll_rdata",  RDATA,           32'h00000000);
    chk("coll_bvalid", {31'd0, BVALID}, 32'd1);
    BREADY = 1'b1; RREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0; RREADY = 1'b0;
    chk("coll_rvalid_clear", {31'd0, RVALID}, 32'd0);
    do_read(4'hC, 0, 0, 1'b0, 32'h12345678);

    // Reset while a write address is latched
    AWADDR = 4'h0; WDATA = 32'h55AA55AA; WSTRB = 4'hF;
    AWVALID = 1'b1;
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    chk("hala_awready", {31'd0, AWREADY}, 32'd0);
    chk("hala_wready",  {31'd0, WREADY},  32'd1);
    #2;
    ARESETn = 1'b0;
    #1;
    chk("arst_awready", {31'd0, AWREADY}, 32'd1);
    chk("arst_wready",  {31'd0, WREADY},  32'd1);
    chk("arst_bvalid",  {31'd0, BVALID},  32'd0);
    chk("arst_rdata",   RDATA,            32'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = '0;
    @(posedge ACLK); #1;
    repeat (2) begin
      chk("post_rst_bvalid",  {31'd0, BVALID},  32'd0);
      chk("post_rst_awready", {31'd0, AWREADY}, 32'd1);
      chk("post_rst_wready",  {31'd0, WREADY},  32'd1);
      @(posedge ACLK); #1;
    end
    do_read(4'h0, 0, 0, 1'b0, 32'h00000000);
    do_read(4'h4, 0, 0, 1'b0, 32'h00000000);

    // Concurrent random traffic against the byte-strobed model
    fork
      begin
        for (int k = 0; k < 50; k++)
          do_write(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
      end
      begin
        for (int k = 0; k < 50; k++)
          do_read(4'($urandom_range(0, 15)), $urandom_range(0, 1), $urandom_range(0, 2),
                  1'b1, 32'd0);
      end
    join

    for (int r = 0; r < 4; r++) begin
      logic [3:0] a;
      a = 4'(r * 4);
      do_read(a, 0, 0, 1'b1, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
